regbank_core: RTL and testbench

//  Register-file storage that implements the REGBANK side of regbank_if: one write port, two read ports.

---
 rtl/regbank_pkg.sv | 15 +
 rtl/regbank_dbg_fsm.sv | 90 +++++++++
 rtl/regbank_core.sv | 99 +++++++++
 tb/tb_regbank_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register bank and its debug access path.
package regbank_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_PEND = 2'd1,
    DBG_ACK  = 2'd2
  } regbank_dbg_state_t;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_w(input int count);
    return (count > 2) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/regbank_dbg_fsm.sv
// Debug command sequencer: latches one command, waits for a free write slot,
// and raises cpu_hold once a pending debug write has starved long enough.
module regbank_dbg_fsm
  import regbank_pkg::*;
#(
  parameter int REG_WIDTH     = 32,
  parameter int AW            = 4,
  parameter int DBG_STALL_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [REG_WIDTH-1:0] dbg_wdata,
  output logic                 dbg_wr_en,
  output logic [AW-1:0]        dbg_cmd_addr,
  output logic [REG_WIDTH-1:0] dbg_wr_data,
  output logic                 dbg_rd_cap,
  output logic                 dbg_ack,
  output logic                 cpu_hold
);

  localparam int CW = $clog2(DBG_STALL_MAX + 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(DBG_STALL_MAX);

  regbank_dbg_state_t   state_q, state_d;
  logic                 cmd_we_q, cmd_we_d;
  logic [AW-1:0]        cmd_addr_q, cmd_addr_d;
  logic [REG_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [CW-1:0]        stall_q, stall_d;

  // Reset discards any latched command, so an interrupted write never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DBG_IDLE;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_we_d   = cmd_we_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    stall_d    = stall_q;
    case (state_q)
      DBG_IDLE: begin
        if (dbg_req) begin
          cmd_we_d   = dbg_we;
          cmd_addr_d = dbg_addr;
          cmd_data_d = dbg_wdata;
          state_d    = DBG_PEND;
        end
      end
      DBG_PEND: begin
        if (!cmd_we_q || !we) begin
          state_d = DBG_ACK;
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      DBG_ACK: begin
        stall_d = '0;
        state_d = DBG_IDLE;
      end
      default: state_d = DBG_IDLE;
    endcase
  end

  always_comb begin
    dbg_cmd_addr = cmd_addr_q;
    dbg_wr_data  = cmd_data_q;
    dbg_wr_en    = (state_q == DBG_PEND) && cmd_we_q && !we;
    dbg_rd_cap   = (state_q == DBG_PEND) && !cmd_we_q;
    dbg_ack      = (state_q == DBG_ACK);
    cpu_hold     = (state_q == DBG_PEND) && cmd_we_q && (stall_q == STALL_MAX);
  end

endmodule

// File: rtl/regbank_core.sv
// Register file with one CPU write port, two combinational read ports and a debug port.
// Define REGBANK_BYPASS_EN to forward same-cycle CPU write data onto the read ports.
module regbank_core
  import regbank_pkg::*;
#(
  parameter int REG_WIDTH     = 32,
  parameter int REG_COUNT     = 16,
  parameter int ZERO_REG      = 1,
  parameter int DBG_STALL_MAX = 8,
  localparam int AW           = addr_w(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [REG_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr1,
  input  logic [AW-1:0]        raddr2,
  output logic [REG_WIDTH-1:0] rdata1,
  output logic [REG_WIDTH-1:0] rdata2,
  output logic                 cpu_hold,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [REG_WIDTH-1:0] dbg_wdata,
  output logic                 dbg_ack,
  output logic [REG_WIDTH-1:0] dbg_rdata
);

  logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                 dbg_wr_en;
  logic                 dbg_rd_cap;
  logic [AW-1:0]        dbg_cmd_addr;
  logic [REG_WIDTH-1:0] dbg_wr_data;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [REG_WIDTH-1:0] read_reg(input logic [AW-1:0] a);
    return is_zero(a) ? '0 : regs_q[a];
  endfunction

  regbank_dbg_fsm #(
    .REG_WIDTH     (REG_WIDTH),
    .AW            (AW),
    .DBG_STALL_MAX (DBG_STALL_MAX)
  ) u_dbg_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_wr_en    (dbg_wr_en),
    .dbg_cmd_addr (dbg_cmd_addr),
    .dbg_wr_data  (dbg_wr_data),
    .dbg_rd_cap   (dbg_rd_cap),
    .dbg_ack      (dbg_ack),
    .cpu_hold     (cpu_hold)
  );

  // The debug write only fires when the CPU leaves the port free, so the two never collide.
  always_comb begin
    regs_d      = regs_q;
    dbg_rdata_d = dbg_rdata_q;
    if (we) begin
      if (!is_zero(waddr)) regs_d[waddr] = wdata;
    end else if (dbg_wr_en && !is_zero(dbg_cmd_addr)) begin
      regs_d[dbg_cmd_addr] = dbg_wr_data;
    end
    if (dbg_rd_cap) dbg_rdata_d = read_reg(dbg_cmd_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      dbg_rdata_q <= '0;
    end else begin
      regs_q      <= regs_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    rdata1 = read_reg(raddr1);
    rdata2 = read_reg(raddr2);
`ifdef REGBANK_BYPASS_EN
    if (we && (waddr == raddr1) && !is_zero(raddr1)) rdata1 = wdata;
    if (we && (waddr == raddr2) && !is_zero(raddr2)) rdata2 = wdata;
`endif
  end

  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_regbank_core.sv
// Directed bench for regbank_core: CPU ports, debug port, stall/hold and reset behaviour.
module tb_regbank_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        cpu_hold;
  logic        dbg_req, dbg_we;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  int total = 0;
  int bad   = 0;

  regbank_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .cpu_hold  (cpu_hold),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    raddr1 = 4'd3; raddr2 = 4'd5; #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_ack", {31'b0, dbg_ack}, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_hold", {31'b0, cpu_hold}, 32'h0);
    rst_n = 1'b1;
    tick();

    // CPU write r3, visible after the edge
    we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; #1;
`ifdef REGBANK_BYPASS_EN
    chk("wr_same_cycle", rdata1, 32'hDEADBEEF);
`else
    chk("wr_same_cycle", rdata1, 32'h0);
`endif
    tick();
    waddr = 4'd5; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0; #1;
    chk("r3_after", rdata1, 32'hDEADBEEF);
    chk("r5_after", rdata2, 32'hA5A5A5A5);

    // zero register: CPU write and debug write both dropped
    we = 1'b1; waddr = 4'd0; wdata = 32'h1234; raddr1 = 4'd0;
    tick();
    we = 1'b0; #1;
    chk("r0_cpu", rdata1, 32'h0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd0; dbg_wdata = 32'h55;
    tick();
    dbg_req = 1'b0; #1;
    chk("r0_dbg_pend_ack", {31'b0, dbg_ack}, 32'h0);
    tick();
    raddr2 = 4'd0; #1;
    chk("r0_dbg_ack", {31'b0, dbg_ack}, 32'h1);
    chk("r0_dbg_rd1", rdata1, 32'h0);
    chk("r0_dbg_rd2", rdata2, 32'h0);
    tick();
    chk("r0_ack_drop", {31'b0, dbg_ack}, 32'h0);

    // debug read r5
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd5;
    tick();
    dbg_req = 1'b0; #1;
    chk("rd5_pend_ack", {31'b0, dbg_ack}, 32'h0);
    tick();
    chk("rd5_ack", {31'b0, dbg_ack}, 32'h1);
    chk("rd5_data", dbg_rdata, 32'hA5A5A5A5);
    tick();
    chk("rd5_ack_drop", {31'b0, dbg_ack}, 32'h0);
    chk("rd5_data_hold", dbg_rdata, 32'hA5A5A5A5);

    // debug read of r3 racing a CPU write to r3 returns the old value
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd3; raddr1 = 4'd3;
    tick();
    dbg_req = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 32'h12345678;
    tick();
    we = 1'b0; #1;
    chk("race_ack", {31'b0, dbg_ack}, 32'h1);
    chk("race_old", dbg_rdata, 32'hDEADBEEF);
    chk("race_cpu", rdata1, 32'h12345678);
    tick();

    // debug write r7 starved by 10 CPU write cycles
    we = 1'b1; waddr = 4'd1; wdata = 32'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd7; dbg_wdata = 32'h77;
    tick();
    dbg_req = 1'b0; #1;
    chk("stall0_hold", {31'b0, cpu_hold}, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      wdata = 32'h11 + k;
      tick();
      if (k == 7) chk("stall7_hold", {31'b0, cpu_hold}, 32'h0);
      if (k >= 8) chk("stall_sat_hold", {31'b0, cpu_hold}, 32'h1);
      chk("stall_ack", {31'b0, dbg_ack}, 32'h0);
    end
    we = 1'b0; raddr1 = 4'd7; raddr2 = 4'd1; #1;
    chk("stall_r7_pending", rdata1, 32'h0);
    tick();
    chk("stall_done_ack", {31'b0, dbg_ack}, 32'h1);
    chk("stall_done_hold", {31'b0, cpu_hold}, 32'h0);
    chk("stall_r7", rdata1, 32'h77);
    chk("stall_r1", rdata2, 32'h1A);
    tick();
    chk("stall_ack_drop", {31'b0, dbg_ack}, 32'h0);

    // counter was cleared: 7 more stalls must not raise cpu_hold
    we = 1'b1; waddr = 4'd1; wdata = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd8; dbg_wdata = 32'h88;
    tick();
    dbg_req = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    chk("cnt_cleared_hold", {31'b0, cpu_hold}, 32'h0);
    we = 1'b0; raddr1 = 4'd8;
    tick();
    chk("r8_ack", {31'b0, dbg_ack}, 32'h1);
    chk("r8_data", rdata1, 32'h88);
    tick();

    // same-cycle forwarding on port 2, never for the zero register
    we = 1'b1; waddr = 4'd4; wdata = 32'hCAFE; raddr2 = 4'd4; #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_r4", rdata2, 32'hCAFE);
`else
    chk("bypass_r4", rdata2, 32'h0);
`endif
    waddr = 4'd0; raddr1 = 4'd0; #1;
    chk("bypass_r0", rdata1, 32'h0);
    waddr = 4'd4;
    tick();
    we = 1'b0; #1;
    chk("r4_after", rdata2, 32'hCAFE);

    // reset while a debug write r2 is pending
    we = 1'b1; waddr = 4'd6; wdata = 32'h66;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd2; dbg_wdata = 32'h9;
    tick();
    dbg_req = 1'b0;
    tick();
    rst_n = 1'b0; #2;
    chk("rstmid_ack", {31'b0, dbg_ack}, 32'h0);
    chk("rstmid_hold", {31'b0, cpu_hold}, 32'h0);
    rst_n = 1'b1; we = 1'b0; raddr1 = 4'd2; raddr2 = 4'd6;
    tick();
    chk("rstmid_ack1", {31'b0, dbg_ack}, 32'h0);
    chk("rstmid_r2", rdata1, 32'h0);
    chk("rstmid_r6", rdata2, 32'h0);
    tick();
    chk("rstmid_ack2", {31'b0, dbg_ack}, 32'h0);
    chk("rstmid_r2_late", rdata1, 32'h0);

    // FSM accepts a fresh command immediately, so it came back in IDLE
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd2; dbg_wdata = 32'h2A;
    tick();
    dbg_req = 1'b0;
    tick();
    chk("post_rst_ack", {31'b0, dbg_ack}, 32'h1);
    chk("post_rst_r2", rdata1, 32'h2A);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
